// File: rtl/instruction_fetch_unit.sv
// RISC-V instruction fetch stage: PC generation, instruction memory read handshake and IF/ID register.
// Define IF_PERF_COUNT_EN to add the fetch/miss performance counter outputs.
//
// state     | meaning
// S_FETCH   | read request at pc; load IF/ID on completion
// S_DISCARD | miss outstanding after a redirect; drop returned data, then jump to pend_pc
// S_HOLD    | fetched word parked in hold buffer while decode is stalled; no request
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        i_mem_read,
    output logic [31:0] i_mem_address,
    input  logic [31:0] i_mem_readdata,
    input  logic        i_mem_busywait,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid
`ifdef IF_PERF_COUNT_EN
    ,
    output logic [31:0] perf_fetch_count,
    output logic [31:0] perf_miss_cycles
`endif
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DISCARD = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic        if_id_valid_q, if_id_valid_d;

    logic        complete;
    logic        deliver;
    logic [31:0] redirect_tgt;
    logic [31:0] pc_plus4;

    assign i_mem_read        = (state_q != S_HOLD);
    assign i_mem_address     = pc_q;
    assign complete          = i_mem_read && !i_mem_busywait;
    assign redirect_tgt      = redirect_pc & ~32'h0000_0003;
    assign pc_plus4          = pc_q + 32'd4;
    assign if_id_instruction = if_id_instr_q;
    assign if_id_pc          = if_id_pc_q;
    assign if_id_valid       = if_id_valid_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_pc_d     = pend_pc_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_valid_d = if_id_valid_q;
        deliver       = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (complete) begin
                    if (redirect) begin
                        pc_d          = redirect_tgt;
                        if_id_instr_d = NOP_INSTR;
                        if_id_valid_d = 1'b0;
                    end else if (stall) begin
                        hold_instr_d = i_mem_readdata;
                        hold_pc_d    = pc_q;
                        pc_d         = pc_plus4;
                        state_d      = S_HOLD;
                    end else begin
                        if_id_instr_d = i_mem_readdata;
                        if_id_pc_d    = pc_q;
                        if_id_valid_d = 1'b1;
                        pc_d          = pc_plus4;
                        deliver       = 1'b1;
                    end
                end else if (redirect) begin
                    // Request must stay stable, so the target waits in pend_pc.
                    pend_pc_d     = redirect_tgt;
                    state_d       = S_DISCARD;
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                end else if (!stall) begin
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                end
            end

            S_DISCARD: begin
                if (redirect) begin
                    pend_pc_d = redirect_tgt;
                end
                if (complete) begin
                    pc_d    = redirect ? redirect_tgt : pend_pc_q;
                    state_d = S_FETCH;
                end
                if (redirect || !stall) begin
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    pc_d          = redirect_tgt;
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                    state_d       = S_FETCH;
                end else if (!stall) begin
                    if_id_instr_d = hold_instr_q;
                    if_id_pc_d    = hold_pc_q;
                    if_id_valid_d = 1'b1;
                    deliver       = 1'b1;
                    state_d       = S_FETCH;
                end
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            pend_pc_q     <= 32'h0;
            hold_instr_q  <= NOP_INSTR;
            hold_pc_q     <= 32'h0;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc_q    <= 32'h0;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_pc_q     <= pend_pc_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc_q     <= hold_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

`ifdef IF_PERF_COUNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        if (deliver) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (i_mem_read && i_mem_busywait) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= 32'h0;
            miss_cnt_q  <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign perf_fetch_count = fetch_cnt_q;
    assign perf_miss_cycles = miss_cnt_q;
`else
    logic unused_deliver;
    assign unused_deliver = deliver;
`endif

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front end of the RISC-V pipeline.
- Generates the PC, drives read requests to the instruction memory/cache over a read/busywait handshake, and loads the IF/ID pipeline register consumed by instruction_decode_unit.
- Handles decode stalls, and branch/jump redirects that arrive while a cache miss is outstanding.
- Sequential throughout: PC register, 3-state FSM, hold buffer, pending-redirect register.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- stall  input  1  hazard unit: hold IF/ID and PC.
- redirect  input  1  branch/jump taken; flush and refetch.
- redirect_pc  input  32  target address for redirect.
- i_mem_read  output  1  instruction memory read request.
- i_mem_address  output  32  word address of request, byte-addressed, bits[1:0]=0.
- i_mem_readdata  input  32  returned instruction; valid when i_mem_read=1 and i_mem_busywait=0.
- i_mem_busywait  input  1  memory not ready; request must be held stable.
- if_id_instruction  output  32  instruction to decode.
- if_id_pc  output  32  PC of if_id_instruction.
- if_id_valid  output  1  1 = real instruction, 0 = bubble.

Behaviour:
- Reset (sync, highest priority, also mid-miss):
  - pc=RESET_PC, state=FETCH, pending flag=0.
  - if_id_instruction=NOP_INSTR, if_id_pc=0, if_id_valid=0.
  - i_mem_read goes high in the first cycle after reset.
- Access completes in any cycle with i_mem_read=1 and i_mem_busywait=0. A hit therefore sustains 1 instr/cycle. i_mem_address=pc; pc is stable while busywait=1.
- PC increment is pc+4, wrapping mod 2^32 (32'hFFFF_FFFC -> 0). redirect_pc[1:0] is forced to 0.
- Bubble: if_id_instruction=NOP_INSTR, if_id_valid=0, if_id_pc unchanged.
- FETCH (i_mem_read=1):
  - Complete and redirect: pc<=redirect_pc, IF/ID<=bubble, stay FETCH. Fetched data is dropped.
  - Complete and stall: hold_reg<=readdata, hold_pc<=pc, pc<=pc+4, go HOLD. IF/ID unchanged.
  - Complete, no stall: IF/ID<={readdata, pc, 1}, pc<=pc+4.
  - Busywait and redirect: pend_pc<=redirect_pc, go DISCARD, IF/ID<=bubble.
  - Busywait, no redirect: IF/ID<=bubble if stall=0, else unchanged.
- DISCARD (i_mem_read=1, address held at old pc):
  - A new redirect overwrites pend_pc (latest wins).
  - On completion: data dropped, pc<=pend_pc (or the same-cycle redirect_pc), go FETCH.
  - IF/ID<=bubble unless stall=1.
- HOLD (i_mem_read=0):
  - redirect: hold dropped, pc<=redirect_pc, IF/ID<=bubble, go FETCH.
  - stall=0: IF/ID<={hold_reg, hold_pc, 1}, go FETCH.
  - stall=1: remain.
- redirect overrides stall: a flush always bubbles IF/ID.
- No fetched instruction is ever lost or duplicated. The ordered PC sequence in IF/ID with valid=1 equals the architectural sequence.

Optional Feature:
- IF_PERF_COUNT_EN defined: adds outputs perf_fetch_count[31:0] and perf_miss_cycles[31:0].
  - perf_fetch_count increments on each instruction delivered to IF/ID with valid=1.
  - perf_miss_cycles increments on each cycle with i_mem_read=1 and busywait=1.
  - Both clear on reset and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, busywait=0 constant, readdata=pc-derived -> if_id_pc sequence 0,4,8,12 with valid=1 from 2nd cycle, one per cycle.
- Miss of 3 cycles at pc=8 -> i_mem_address=8 stable for 4 cycles, 3 bubbles, then if_id_pc=8 valid=1.
- Stall asserted for 2 cycles while pc=12 hits -> IF/ID holds pc=8 entry, HOLD entered, then pc=12 delivered once, pc=16 follows, no gap or duplicate.
- redirect to 0x100 during a miss at pc=0x20 -> address stays 0x20 until busywait drops, 0x20 data discarded, next request 0x100, first valid if_id_pc=0x100.
- redirect to 0x40 then 0x80 in consecutive DISCARD cycles -> fetch resumes at 0x80; redirect with stall=1 in HOLD -> IF/ID bubble, next valid pc=target.
- reset pulsed mid-miss -> next cycle pc=RESET_PC, valid=0, i_mem_address=0; with IF_PERF_COUNT_EN, counters read 0.
